branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- ID-stage branch resolution and stall control for the 5-stage pipeline.
- Sits directly downstream of the ID-stage register comparator and consumes its equality flag for the beq decode (ALU op 4'b0111).
- Holds the branch for the required number of cycles while a source operand is still in flight, then drives PC select, branch target and the IF/ID flush.

Parameters:
- ADDR_W, 32, PC/immediate width
- REG_AW, 5, register-index width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- branch_i  in  1  ID instruction is beq (op 4'b0111)
- equal_i  in  1  equality flag from the ID-stage comparator
- pc_plus4_i  in  ADDR_W  PC+4 of the ID instruction
- imm_i  in  ADDR_W  sign-extended branch offset, in words
- rs_i, rt_i  in  REG_AW  ID source register indices
- ex_rd_i  in  REG_AW  EX destination register
- ex_regwrite_i  in  1  EX writes a register
- ex_memread_i  in  1  EX instruction is a load
- mem_rd_i  in  REG_AW  MEM destination register
- mem_memread_i  in  1  MEM instruction is a load
- stall_o  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- pc_src_o  out  1  select target_o as the next PC
- flush_o  out  1  zero IF/ID (squash the fetched instruction)
- target_o  out  ADDR_W  pc_plus4_i + (imm_i << 2), modulo 2^ADDR_W

Behaviour:
- Hit condition: hit(r) = (r != 0) && (r == rs_i || r == rt_i).
- need is computed combinationally from the first matching line below:
  - 2 if ex_memread_i && hit(ex_rd_i)
  - else 1 if ex_regwrite_i && !ex_memread_i && hit(ex_rd_i)
  - else 1 if mem_memread_i && hit(mem_rd_i)
  - else 0
- State: states IDLE and STALL; 2-bit register rem.
- Reset values: state=IDLE, rem=0.
- Output gating: while rst_i=1, stall_o, pc_src_o and flush_o are forced to 0 regardless of state.
- IDLE, branch_i=1, need>0:
  - stall_o=1; rem<=need-1.
  - Next state: STALL if need-1>0, else IDLE.
  - pc_src_o=0, flush_o=0.
- IDLE, branch_i=1, need=0:
  - Resolve in the same cycle (zero latency): pc_src_o=flush_o=equal_i; stall_o=0.
- IDLE, branch_i=0: all control outputs 0.
- STALL:
  - stall_o=1; pc_src_o=flush_o=0; rem<=rem-1.
  - Next state: IDLE when rem==1, else stay in STALL.
  - Hazard inputs, branch_i and equal_i are ignored.
- After STALL, IDLE re-evaluates need. A nonzero need there produces a further stall; it is not an error.
- Total stalls: 2 for an EX load hit, 1 for an EX ALU hit, 1 for a MEM load hit.
- A MEM ALU result is not stalled on (forwarded to the comparator).
- Register $0 never causes a hazard.
- target_o is purely combinational, valid every cycle and unaffected by reset. Overflow wraps.
- Reset asserted in STALL: next cycle is IDLE with rem=0, and no flush is issued.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds three outputs:
  - taken_cnt_o, 32-bit: +1 on each resolution with equal_i=1
  - nottaken_cnt_o, 32-bit: +1 on each resolution with equal_i=0
  - stall_cnt_o, 32-bit: +1 on every cycle with stall_o=1
- All three reset to 0 on rst_i and wrap 0xFFFFFFFF -> 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- No hazard: branch_i=1, equal_i=1, pc_plus4_i=0x100, imm_i=0x4 -> same cycle pc_src_o=1, flush_o=1, stall_o=0, target_o=0x110.
- Same stimulus with equal_i=0 -> pc_src_o=0, flush_o=0, target_o=0x110; with imm_i=0xFFFFFFFF -> target_o=0xFC.
- EX ALU hit: ex_rd_i=5, ex_regwrite_i=1, rs_i=5 -> stall_o=1 for exactly 1 cycle; hazard cleared next cycle -> resolves with equal_i.
- EX load hit: ex_rd_i=7, ex_memread_i=1, rt_i=7 -> stall_o=1 for 2 cycles (IDLE then STALL); resolves on the 3rd cycle.
- ex_rd_i=0 with rs_i=0 and loads active -> no stall.
- rst_i pulsed during STALL -> outputs 0 in that cycle; IDLE the next cycle.
- BRANCH_STATS_EN: run one taken, one not-taken and one EX load hit -> taken_cnt_o=1 (2 if the load-hit branch is taken), nottaken_cnt_o=1, stall_cnt_o=2.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// ID-stage beq resolution with load/ALU hazard stall control.
// Optional macro BRANCH_STATS_EN adds taken/not-taken/stall event counters.
module branch_resolve_ctrl #(
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              branch_i,
    input  logic              equal_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [ADDR_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_memread_i,
    output logic              stall_o,
    output logic              pc_src_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] target_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       taken_cnt_o,
    output logic [31:0]       nottaken_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t     state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic [1:0] need;
    logic       resolve;

    function automatic logic hit(input logic [REG_AW-1:0] r,
                                 input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rt);
        return (r != '0) && ((r == rs) || (r == rt));
    endfunction

    // A MEM-stage ALU result is forwarded to the comparator, so only loads stall there.
    always_comb begin
        need = 2'd0;
        if (ex_memread_i && hit(ex_rd_i, rs_i, rt_i))
            need = 2'd2;
        else if (ex_regwrite_i && !ex_memread_i && hit(ex_rd_i, rs_i, rt_i))
            need = 2'd1;
        else if (mem_memread_i && hit(mem_rd_i, rs_i, rt_i))
            need = 2'd1;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        stall_o  = 1'b0;
        pc_src_o = 1'b0;
        flush_o  = 1'b0;
        resolve  = 1'b0;
        case (state_q)
            IDLE: begin
                if (branch_i) begin
                    if (need != 2'd0) begin
                        stall_o = 1'b1;
                        rem_d   = need - 2'd1;
                        state_d = (need != 2'd1) ? STALL : IDLE;
                    end else begin
                        resolve  = 1'b1;
                        pc_src_o = equal_i;
                        flush_o  = equal_i;
                    end
                end
            end
            STALL: begin
                stall_o = 1'b1;
                rem_d   = rem_q - 2'd1;
                state_d = (rem_q == 2'd1) ? IDLE : STALL;
            end
            default: state_d = IDLE;
        endcase
        // Reset wins over any in-progress stall or resolution.
        if (rst_i) begin
            stall_o  = 1'b0;
            pc_src_o = 1'b0;
            flush_o  = 1'b0;
            resolve  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign target_o = pc_plus4_i + (imm_i << 2);

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] nottaken_cnt_q, nottaken_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        taken_cnt_d    = taken_cnt_q + {31'd0, resolve & equal_i};
        nottaken_cnt_d = nottaken_cnt_q + {31'd0, resolve & ~equal_i};
        stall_cnt_d    = stall_cnt_q + {31'd0, stall_o};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taken_cnt_q    <= 32'd0;
            nottaken_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign taken_cnt_o    = taken_cnt_q;
    assign nottaken_cnt_o = nottaken_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: stall lengths, same-cycle resolution, reset gating.
module tb_branch_resolve_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_i, equal_i;
    logic [31:0] pc_plus4_i, imm_i;
    logic [4:0]  rs_i, rt_i, ex_rd_i, mem_rd_i;
    logic        ex_regwrite_i, ex_memread_i, mem_memread_i;
    logic        stall_o, pc_src_o, flush_o;
    logic [31:0] target_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_o, nottaken_cnt_o, stall_cnt_o;
`endif

    int n_chk = 0;
    int n_err = 0;

    branch_resolve_ctrl #(.ADDR_W(32), .REG_AW(5)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .branch_i      (branch_i),
        .equal_i       (equal_i),
        .pc_plus4_i    (pc_plus4_i),
        .imm_i         (imm_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .ex_rd_i       (ex_rd_i),
        .ex_regwrite_i (ex_regwrite_i),
        .ex_memread_i  (ex_memread_i),
        .mem_rd_i      (mem_rd_i),
        .mem_memread_i (mem_memread_i),
        .stall_o       (stall_o),
        .pc_src_o      (pc_src_o),
        .flush_o       (flush_o),
        .target_o      (target_o)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt_o   (taken_cnt_o),
        .nottaken_cnt_o(nottaken_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic s, input logic p, input logic f);
        chk({tag, ".stall"}, {31'd0, stall_o}, {31'd0, s});
        chk({tag, ".pc_src"}, {31'd0, pc_src_o}, {31'd0, p});
        chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, f});
    endtask

    // Start a new cycle: quiet inputs applied at the falling edge.
    task automatic cyc();
        @(negedge clk_i);
        rst_i         = 1'b0;
        branch_i      = 1'b0;
        equal_i       = 1'b0;
        pc_plus4_i    = 32'h100;
        imm_i         = 32'h4;
        rs_i          = 5'd1;
        rt_i          = 5'd2;
        ex_rd_i       = 5'd0;
        ex_regwrite_i = 1'b0;
        ex_memread_i  = 1'b0;
        mem_rd_i      = 5'd0;
        mem_memread_i = 1'b0;
    endtask

    initial begin
        // Reset with an otherwise resolvable taken branch: outputs gated.
        cyc(); rst_i = 1'b1; branch_i = 1'b1; equal_i = 1'b1; #1;
        ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.target", target_o, 32'h110);
        cyc(); rst_i = 1'b1; #1;

        cyc(); branch_i = 1'b1; equal_i = 1'b1; #1;
        ctl("nohaz_taken", 1'b0, 1'b1, 1'b1);
        chk("nohaz_taken.target", target_o, 32'h110);

        cyc(); branch_i = 1'b1; equal_i = 1'b0; #1;
        ctl("nohaz_nt", 1'b0, 1'b0, 1'b0);
        chk("nohaz_nt.target", target_o, 32'h110);

        cyc(); branch_i = 1'b1; imm_i = 32'hFFFF_FFFF; #1;
        chk("neg_imm.target", target_o, 32'hFC);

        cyc(); branch_i = 1'b0; ex_rd_i = 5'd1; ex_memread_i = 1'b1; #1;
        ctl("nobranch", 1'b0, 1'b0, 1'b0);

        // EX ALU hit: one stall cycle, then resolve.
        cyc(); branch_i = 1'b1; equal_i = 1'b1; rs_i = 5'd5; ex_rd_i = 5'd5; ex_regwrite_i = 1'b1; #1;
        ctl("exalu.c1", 1'b1, 1'b0, 1'b0);
        cyc(); branch_i = 1'b1; equal_i = 1'b1; #1;
        ctl("exalu.c2", 1'b0, 1'b1, 1'b1);

        // EX load hit: two stall cycles; STALL ignores equal_i.
        cyc(); branch_i = 1'b1; rt_i = 5'd7; ex_rd_i = 5'd7; ex_memread_i = 1'b1; ex_regwrite_i = 1'b1; #1;
        ctl("exld.c1", 1'b1, 1'b0, 1'b0);
        cyc(); branch_i = 1'b1; equal_i = 1'b1; #1;
        ctl("exld.c2", 1'b1, 1'b0, 1'b0);
        cyc(); branch_i = 1'b1; equal_i = 1'b1; #1;
        ctl("exld.c3", 1'b0, 1'b1, 1'b1);

        // MEM load hit: one stall.
        cyc(); branch_i = 1'b1; rs_i = 5'd3; mem_rd_i = 5'd3; mem_memread_i = 1'b1; #1;
        ctl("memld.c1", 1'b1, 1'b0, 1'b0);
        cyc(); branch_i = 1'b1; #1;
        ctl("memld.c2", 1'b0, 1'b0, 1'b0);

        // MEM ALU result is forwarded, no stall.
        cyc(); branch_i = 1'b1; equal_i = 1'b1; rs_i = 5'd3; mem_rd_i = 5'd3; #1;
        ctl("memalu", 1'b0, 1'b1, 1'b1);

        // $0 never hazards even with loads in EX and MEM.
        cyc(); branch_i = 1'b1; equal_i = 1'b1; rs_i = 5'd0; rt_i = 5'd0;
        ex_memread_i = 1'b1; mem_memread_i = 1'b1; #1;
        ctl("reg0", 1'b0, 1'b1, 1'b1);

        // Hazard still present after STALL produces a further stall.
        cyc(); branch_i = 1'b1; rs_i = 5'd9; ex_rd_i = 5'd9; ex_memread_i = 1'b1; #1;
        ctl("restall.c1", 1'b1, 1'b0, 1'b0);
        cyc(); branch_i = 1'b1; #1;
        ctl("restall.c2", 1'b1, 1'b0, 1'b0);
        cyc(); branch_i = 1'b1; rs_i = 5'd9; ex_rd_i = 5'd9; ex_regwrite_i = 1'b1; #1;
        ctl("restall.c3", 1'b1, 1'b0, 1'b0);
        cyc(); branch_i = 1'b1; equal_i = 1'b1; #1;
        ctl("restall.c4", 1'b0, 1'b1, 1'b1);

        // Reset during STALL: gated that cycle, IDLE the next.
        cyc(); branch_i = 1'b1; rs_i = 5'd4; ex_rd_i = 5'd4; ex_memread_i = 1'b1; #1;
        ctl("rststall.c1", 1'b1, 1'b0, 1'b0);
        cyc(); rst_i = 1'b1; branch_i = 1'b1; equal_i = 1'b1; #1;
        ctl("rststall.c2", 1'b0, 1'b0, 1'b0);
        cyc(); branch_i = 1'b1; equal_i = 1'b1; #1;
        ctl("rststall.c3", 1'b0, 1'b1, 1'b1);

`ifdef BRANCH_STATS_EN
        cyc(); rst_i = 1'b1; #1;
        cyc(); #1;
        chk("stats.rst_taken", taken_cnt_o, 32'd0);
        chk("stats.rst_stall", stall_cnt_o, 32'd0);
        cyc(); branch_i = 1'b1; equal_i = 1'b1; #1;
        cyc(); branch_i = 1'b1; equal_i = 1'b0; #1;
        cyc(); branch_i = 1'b1; rs_i = 5'd6; ex_rd_i = 5'd6; ex_memread_i = 1'b1; #1;
        cyc(); branch_i = 1'b1; #1;
        cyc(); branch_i = 1'b1; equal_i = 1'b1; #1;
        cyc(); #1;
        chk("stats.taken", taken_cnt_o, 32'd2);
        chk("stats.nottaken", nottaken_cnt_o, 32'd1);
        chk("stats.stall", stall_cnt_o, 32'd2);
`endif

        cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
